mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register in the 32-bit pipelined core.
- Consumes the EX/MEM outputs (ALU result as address, store data, rd, memory/writeback controls).
- Performs word load/store through a req/ready data-memory handshake, stalling upstream while an access is outstanding.
- Registers the results into the MEM/WB boundary for writeback.

Parameters:
- TIMEOUT_CYCLES, 16: max BUSY cycles waiting for dmem_ready before aborting the access.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset; acts on posedge when 0.
- alu_MEM  in  32  effective address or ALU result.
- writedata_MEM  in  32  store data.
- rd_MEM  in  5  destination register.
- memread_MEM  in  1  load request.
- memwrite_MEM  in  1  store request.
- memtoreg_MEM  in  1  writeback selects load data.
- regwrite_MEM  in  1  register write enable.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- dmem_addr  out  32  word address (byte address, [1:0]=0).
- dmem_wdata  out  32  store data.
- dmem_ready  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  load data; valid when dmem_ready=1.
- stall_mem  out  1  combinational; freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- readdata_WB  out  32  load data.
- alu_WB  out  32  ALU result passthrough.
- rd_WB  out  5  destination register.
- memtoreg_WB  out  1  writeback mux select.
- regwrite_WB  out  1  writeback enable.
- mem_err_WB  out  1  faulting access (misaligned, illegal, or timeout).

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, counter=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - All *_WB outputs = 0.
  - stall_mem=0 while rst=0.
  - Reset mid-access drops dmem_req the next cycle; no data is captured.
- Op classification, in IDLE:
  - memop = memread_MEM | memwrite_MEM.
  - illegal = memread_MEM & memwrite_MEM.
  - misaligned = memop & (alu_MEM[1:0] != 0).
- IDLE, no memop: MEM/WB loads alu_WB, rd_WB, memtoreg_WB and regwrite_WB from inputs; readdata_WB=0, mem_err_WB=0. Latency is 1 cycle, and there is no stall.
- IDLE, illegal or misaligned: no request is issued. MEM/WB loads with regwrite_WB=0 and mem_err_WB=1 (rd_WB and alu_WB passthrough). No stall.
- IDLE, legal memop:
  - stall_mem=1 this cycle.
  - Next cycle: state=BUSY, dmem_req=1, dmem_we=memwrite_MEM, dmem_addr=alu_MEM, dmem_wdata=writedata_MEM, counter=0.
  - Controls, rd and ALU result are latched internally.
  - MEM/WB loads a bubble: regwrite_WB=0, mem_err_WB=0.
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable until completion.
  - stall_mem = !dmem_ready.
  - On dmem_ready=1:
    - MEM/WB loads the latched fields; readdata_WB = dmem_rdata for loads, 0 for stores.
    - regwrite_WB = latched regwrite; mem_err_WB=0.
    - Next cycle: dmem_req=0, state=IDLE. stall_mem=0 in the completing cycle.
  - On dmem_ready=0 with counter < TIMEOUT_CYCLES-1: counter increments; MEM/WB loads a bubble.
  - On dmem_ready=0 with counter == TIMEOUT_CYCLES-1 (abort):
    - stall_mem=0 this cycle.
    - MEM/WB loads regwrite_WB=0, mem_err_WB=1.
    - Next cycle: dmem_req=0, state=IDLE.
- Minimum load/store latency is 2 cycles, with ready on the first BUSY cycle.
- dmem_ready while IDLE is ignored.
- Inputs are held stable by upstream while stall_mem=1. The latched copy is authoritative in BUSY.
- Back-to-back legal memops: the completion cycle returns to IDLE, and the next op starts in the following cycle. There is no request overlap.

Decomposition:
- Shared package (pipeline_pkg):
  - mem_state_t enum {IDLE, BUSY}.
  - Constants WORD_W=32, REG_ADDR_W=5, DEFAULT_TIMEOUT=16.
- One natural sub-module: mem_wb_reg, the MEM/WB register with load and bubble inputs, holding the *_WB outputs. The FSM, handshake and timeout stay in mem_stage.

Test Plan:
- ALU op (alu_MEM=0x0000_1234, rd=5, regwrite=1, no memop) -> next cycle alu_WB=0x1234, rd_WB=5, regwrite_WB=1; stall_mem never 1; dmem_req stays 0.
- Load from addr 0x100, ready after 3 BUSY cycles with rdata=0xDEADBEEF:
  - dmem_req high for 3 cycles with addr=0x100 and we=0.
  - stall_mem high for 3 cycles total.
  - Then readdata_WB=0xDEADBEEF, memtoreg_WB=1, regwrite_WB=1.
- Store 0xCAFEF00D to 0x204, ready on first BUSY cycle -> dmem_we=1, wdata=0xCAFEF00D for 1 cycle; stall 1 cycle; regwrite_WB=0, mem_err_WB=0.
- Misaligned load at 0x102 -> no dmem_req, no stall; next cycle mem_err_WB=1, regwrite_WB=0.
- Load with dmem_ready never asserted, TIMEOUT_CYCLES=16 -> req high 16 cycles, then mem_err_WB=1, regwrite_WB=0, dmem_req=0, stall released.
- rst=0 on the second BUSY cycle of a load -> next cycle dmem_req=0 and all *_WB=0; a later ready pulse is ignored.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 32-bit pipelined core.
// Includes the MEM-stage FSM encoding and a small address helper.
package pipeline_pkg;

  localparam int WORD_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Word accesses only: any set bit in [1:0] is a misaligned address.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. load_i captures the d-side fields.
// bubble_i clears every field. With neither asserted, the register holds its value.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic [WORD_W-1:0]     readdata_i,
  input  logic [WORD_W-1:0]     alu_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  memtoreg_i,
  input  logic                  regwrite_i,
  input  logic                  err_i,
  output logic [WORD_W-1:0]     readdata_o,
  output logic [WORD_W-1:0]     alu_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  memtoreg_o,
  output logic                  regwrite_o,
  output logic                  err_o
);

  logic [WORD_W-1:0]     readdata_q;
  logic [WORD_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  memtoreg_q;
  logic                  regwrite_q;
  logic                  err_q;

  always_ff @(posedge clk) begin
    if (!rst || bubble_i) begin
      readdata_q <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (load_i) begin
      readdata_q <= readdata_i;
      alu_q      <= alu_i;
      rd_q       <= rd_i;
      memtoreg_q <= memtoreg_i;
      regwrite_q <= regwrite_i;
      err_q      <= err_i;
    end
  end

  assign readdata_o = readdata_q;
  assign alu_o      = alu_q;
  assign rd_o       = rd_q;
  assign memtoreg_o = memtoreg_q;
  assign regwrite_o = regwrite_q;
  assign err_o      = err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. It performs word load/store over a req/ready data-memory port, with timeout.
// It stalls upstream while an access is outstanding and feeds the MEM/WB register.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     alu_MEM,
  input  logic [WORD_W-1:0]     writedata_MEM,
  input  logic [REG_ADDR_W-1:0] rd_MEM,
  input  logic                  memread_MEM,
  input  logic                  memwrite_MEM,
  input  logic                  memtoreg_MEM,
  input  logic                  regwrite_MEM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [WORD_W-1:0]     dmem_rdata,
  output logic                  stall_mem,
  output logic [WORD_W-1:0]     readdata_WB,
  output logic [WORD_W-1:0]     alu_WB,
  output logic [REG_ADDR_W-1:0] rd_WB,
  output logic                  memtoreg_WB,
  output logic                  regwrite_WB,
  output logic                  mem_err_WB,
  output mem_state_t            mem_state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t            state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  req_q;
  logic                  we_q;
  logic [WORD_W-1:0]     addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  memtoreg_q;
  logic                  regwrite_q;

  logic memop, illegal, misaligned;
  logic start, fault, abort;

  assign memop      = memread_MEM | memwrite_MEM;
  assign illegal    = memread_MEM & memwrite_MEM;
  assign misaligned = memop & is_misaligned(alu_MEM);

  assign start = (state_q == IDLE) & memop & ~illegal & ~misaligned;
  assign fault = (state_q == IDLE) & (illegal | misaligned);
  assign abort = (state_q == BUSY) & ~dmem_ready & (cnt_q == CNT_LAST);

  assign stall_mem = rst & (start | ((state_q == BUSY) & ~dmem_ready & ~abort));

  // dmem handshake: req and its payload are registered and held stable while req=1.
  // The transfer completes in the cycle where req and ready are both 1. Ready is ignored while req=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= BUSY;
            cnt_q      <= '0;
            req_q      <= 1'b1;
            we_q       <= memwrite_MEM;
            addr_q     <= alu_MEM;
            wdata_q    <= writedata_MEM;
            rd_q       <= rd_MEM;
            memtoreg_q <= memtoreg_MEM;
            regwrite_q <= regwrite_MEM;
          end
        end
        BUSY: begin
          if (dmem_ready || abort) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  logic                  wb_load_d;
  logic                  wb_bubble_d;
  logic [WORD_W-1:0]     wb_readdata_d;
  logic [WORD_W-1:0]     wb_alu_d;
  logic [REG_ADDR_W-1:0] wb_rd_d;
  logic                  wb_memtoreg_d;
  logic                  wb_regwrite_d;
  logic                  wb_err_d;

  // The latched address doubles as the ALU result for memory ops.
  always_comb begin
    wb_load_d     = 1'b1;
    wb_bubble_d   = 1'b0;
    wb_readdata_d = '0;
    wb_alu_d      = alu_MEM;
    wb_rd_d       = rd_MEM;
    wb_memtoreg_d = memtoreg_MEM;
    wb_regwrite_d = regwrite_MEM;
    wb_err_d      = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        wb_load_d   = 1'b0;
        wb_bubble_d = 1'b1;
      end else if (fault) begin
        wb_regwrite_d = 1'b0;
        wb_err_d      = 1'b1;
      end
    end else begin
      wb_alu_d      = addr_q;
      wb_rd_d       = rd_q;
      wb_memtoreg_d = memtoreg_q;
      wb_regwrite_d = regwrite_q;
      if (dmem_ready) begin
        wb_readdata_d = we_q ? '0 : dmem_rdata;
      end else if (abort) begin
        wb_regwrite_d = 1'b0;
        wb_err_d      = 1'b1;
      end else begin
        wb_load_d   = 1'b0;
        wb_bubble_d = 1'b1;
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wb_load_d),
    .bubble_i   (wb_bubble_d),
    .readdata_i (wb_readdata_d),
    .alu_i      (wb_alu_d),
    .rd_i       (wb_rd_d),
    .memtoreg_i (wb_memtoreg_d),
    .regwrite_i (wb_regwrite_d),
    .err_i      (wb_err_d),
    .readdata_o (readdata_WB),
    .alu_o      (alu_WB),
    .rd_o       (rd_WB),
    .memtoreg_o (memtoreg_WB),
    .regwrite_o (regwrite_WB),
    .err_o      (mem_err_WB)
  );

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_state_dbg = state_q;

endmodule
